// File: rtl/sarlock_pkg.sv
// Shared types and constants for the SARLock c432 key loader.
// Parity/lockout support is selected by SARLOCK_KEY_PARITY_EN.
package sarlock_pkg;

  localparam int KEY_W_DEF = 24;
  localparam int CNT_W_DEF = 5;

  // Correct unlock key for the SARLock-protected c432 netlist
  localparam logic [23:0] C432_KEY = 24'hB00000;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK,
    COMMIT,
    FAIL
  } state_e;

endpackage

// File: rtl/sarlock_shift_reg.sv
// Shadow key register, LSB-first bit counter and running parity.
// The parity accumulator exists only with SARLOCK_KEY_PARITY_EN.
module sarlock_shift_reg
  import sarlock_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             sdi_i,
  output logic [KEY_W-1:0] shadow_o,
`ifdef SARLOCK_KEY_PARITY_EN
  output logic             par_o,
`endif
  output logic             last_o
);

  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign shadow_o = shadow_q;
  assign last_o   = (cnt_q == CNT_W'(KEY_W - 1));

  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      shadow_d = '0;
      cnt_d    = '0;
    end else if (en_i) begin
      shadow_d[cnt_q] = sdi_i;
      cnt_d = last_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      cnt_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef SARLOCK_KEY_PARITY_EN
  logic par_q, par_d;

  assign par_o = par_q;

  always_comb begin
    par_d = par_q;
    if (clr_i)     par_d = 1'b0;
    else if (en_i) par_d = par_q ^ sdi_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end
`endif

endmodule

// File: rtl/sarlock_key_loader.sv
// Serial key loader feeding keyinput0..N of the SARLock c432 netlist.
// SARLOCK_KEY_PARITY_EN adds the parity check, fail counter and lockout.
module sarlock_key_loader
  import sarlock_pkg::*;
#(
  parameter int KEY_W    = KEY_W_DEF,
`ifdef SARLOCK_KEY_PARITY_EN
  parameter int MAX_FAIL = 3,
`endif
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_start,
  input  logic             key_sdi,
  input  logic             key_sen,
  output logic [KEY_W-1:0] keyinput,
  output logic             key_ready,
  output logic             busy,
  output logic             key_err,
  output logic             lockout
);

  // Async assert, release synchronised to clk
  logic [1:0] rsync_q;
  logic       rst_int;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rsync_q <= 2'b11;
    else     rsync_q <= {rsync_q[0], 1'b0};
  end

  assign rst_int = rsync_q[1];

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             ready_q, ready_d;
  logic [KEY_W-1:0] shadow;
  logic             last;
  logic             locked;
  logic             accept;
  logic             shift_en;

`ifdef SARLOCK_KEY_PARITY_EN
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  logic              par;
  logic              par_ok;
  logic              err_q, err_d;
  logic              lock_q, lock_d;
  logic [FAIL_W-1:0] fail_q, fail_d;

  assign par_ok  = ~(par ^ key_sdi);
  assign locked  = lock_q;
  assign key_err = err_q;
  assign lockout = lock_q;
`else
  assign locked  = 1'b0;
  assign key_err = 1'b0;
  assign lockout = 1'b0;
`endif

  assign accept = key_start &
    (((state_q == IDLE) & ~locked) |
     (state_q == SHIFT) | (state_q == CHECK));
  assign shift_en = (state_q == SHIFT) & key_sen & ~key_start;

  sarlock_shift_reg #(
    .KEY_W(KEY_W),
    .CNT_W(CNT_W)
  ) u_shift (
    .clk     (clk),
    .rst     (rst_int),
    .clr_i   (accept),
    .en_i    (shift_en),
    .sdi_i   (key_sdi),
    .shadow_o(shadow),
`ifdef SARLOCK_KEY_PARITY_EN
    .par_o   (par),
`endif
    .last_o  (last)
  );

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept) state_d = SHIFT;
      SHIFT: begin
        if (key_start) state_d = SHIFT;
`ifdef SARLOCK_KEY_PARITY_EN
        else if (key_sen && last) state_d = CHECK;
`else
        else if (key_sen && last) state_d = COMMIT;
`endif
      end
`ifdef SARLOCK_KEY_PARITY_EN
      CHECK: begin
        if (key_start)    state_d = SHIFT;
        else if (key_sen) state_d = par_ok ? COMMIT : FAIL;
      end
      FAIL:   state_d = IDLE;
`endif
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == SHIFT) | (state_q == CHECK);
    key_d   = key_q;
    ready_d = ready_q;
`ifdef SARLOCK_KEY_PARITY_EN
    err_d   = err_q;
    lock_d  = lock_q;
    fail_d  = fail_q;
    if (accept) err_d = 1'b0;
`endif
    if (accept) ready_d = 1'b0;
    if (state_q == COMMIT) begin
      key_d   = shadow;
      ready_d = 1'b1;
`ifdef SARLOCK_KEY_PARITY_EN
      err_d   = 1'b0;
      fail_d  = '0;
`endif
    end
`ifdef SARLOCK_KEY_PARITY_EN
    if (state_q == FAIL) begin
      key_d   = '0;
      ready_d = 1'b0;
      err_d   = 1'b1;
      if (fail_q != FAIL_W'(MAX_FAIL))
        fail_d = fail_q + FAIL_W'(1);
      if (fail_d == FAIL_W'(MAX_FAIL))
        lock_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      key_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      key_q   <= key_d;
      ready_q <= ready_d;
    end
  end

`ifdef SARLOCK_KEY_PARITY_EN
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      err_q  <= 1'b0;
      lock_q <= 1'b0;
      fail_q <= '0;
    end else begin
      err_q  <= err_d;
      lock_q <= lock_d;
      fail_q <= fail_d;
    end
  end
`endif

  assign keyinput  = key_q;
  assign key_ready = ready_q;

endmodule

// File: tb/tb_sarlock_key_loader.sv
// Directed bench for sarlock_key_loader (both parity build options).
module tb_sarlock_key_loader;
  import sarlock_pkg::*;

  localparam int KW = KEY_W_DEF;
`ifdef SARLOCK_KEY_PARITY_EN
  localparam int FRAME = KW + 1;
`else
  localparam int FRAME = KW;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          key_start;
  logic          key_sdi;
  logic          key_sen;
  logic [KW-1:0] keyinput;
  logic          key_ready;
  logic          busy;
  logic          key_err;
  logic          lockout;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sarlock_key_loader dut (
    .clk      (clk),
    .rst      (rst),
    .key_start(key_start),
    .key_sdi  (key_sdi),
    .key_sen  (key_sen),
    .keyinput (keyinput),
    .key_ready(key_ready),
    .busy     (busy),
    .key_err  (key_err),
    .lockout  (lockout)
  );

  // Full frame: start pulse, FRAME bits (3 idle cycles before bit stall_at),
  // then wait up to 4 cycles for key_ready. lat counts cycles after start.
  task automatic run_frame(input logic [KW-1:0] k, input logic p,
                           input int stall_at, output int lat);
    logic [31:0] f;
    int w;
    f = 32'(k);
    f[KW] = p;
    key_start = 1'b1;
    @(negedge clk);
    key_start = 1'b0;
    lat = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i == stall_at) begin
        repeat (3) begin
          key_sen = 1'b0;
          @(negedge clk);
          lat++;
        end
      end
      key_sen = 1'b1;
      key_sdi = f[i];
      @(negedge clk);
      lat++;
    end
    key_sen = 1'b0;
    w = 0;
    while (!key_ready && w < 4) begin
      @(negedge clk);
      w++;
    end
    lat += w;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if (keyinput !== '0) begin
      miscompares++;
      $display("FAIL reset_key got %h exp 0", keyinput);
    end
    vectors++;
    if (key_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready got %b exp 0", key_ready);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy got %b exp 0", busy);
    end
    vectors++;
    if (lockout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_lockout got %b exp 0", lockout);
    end
    vectors++;
    if (key_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_err got %b exp 0", key_err);
    end
  endtask

  task automatic test_load();
    int lat;
    run_frame(C432_KEY, 1'b1, -1, lat);
    vectors++;
    if (lat !== FRAME + 1) begin
      miscompares++;
      $display("FAIL load_latency got %0d exp %0d", lat, FRAME + 1);
    end
    vectors++;
    if (keyinput !== C432_KEY) begin
      miscompares++;
      $display("FAIL load_key got %h exp %h", keyinput, C432_KEY);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL load_busy got %b exp 0", busy);
    end
    vectors++;
    if (key_err !== 1'b0) begin
      miscompares++;
      $display("FAIL load_err got %b exp 0", key_err);
    end
  endtask

  task automatic test_stall();
    int lat;
    int pos;
    pos = int'($urandom_range(1, FRAME - 2));
    run_frame(C432_KEY, 1'b1, pos, lat);
    vectors++;
    if (lat !== FRAME + 4) begin
      miscompares++;
      $display("FAIL stall_latency got %0d exp %0d", lat, FRAME + 4);
    end
    vectors++;
    if (keyinput !== C432_KEY || key_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_key got %h/%b exp %h/1",
               keyinput, key_ready, C432_KEY);
    end
  endtask

  task automatic test_restart();
    int lat;
    logic [KW-1:0] junk;
    junk = 24'h0F0F0F;
    key_start = 1'b1;
    @(negedge clk);
    key_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      key_sen = 1'b1;
      key_sdi = junk[i];
      @(negedge clk);
    end
    key_sen = 1'b0;
    vectors++;
    if (busy !== 1'b1 || key_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_mid got busy=%b rdy=%b exp 1/0",
               busy, key_ready);
    end
    vectors++;
    if (keyinput !== C432_KEY) begin
      miscompares++;
      $display("FAIL restart_hold got %h exp %h", keyinput, C432_KEY);
    end
    run_frame(24'h123456, 1'b1, -1, lat);
    vectors++;
    if (keyinput !== 24'h123456) begin
      miscompares++;
      $display("FAIL restart_key got %h exp 123456", keyinput);
    end
    vectors++;
    if (lat !== FRAME + 1) begin
      miscompares++;
      $display("FAIL restart_latency got %0d exp %0d", lat, FRAME + 1);
    end
  endtask

  task automatic test_rst_mid();
    int lat;
    key_start = 1'b1;
    @(negedge clk);
    key_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      key_sen = 1'b1;
      key_sdi = C432_KEY[i];
      @(negedge clk);
    end
    key_sen = 1'b0;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (keyinput !== '0 || key_ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async got key=%h rdy=%b busy=%b exp 0/0/0",
               keyinput, key_ready, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || keyinput !== '0) begin
      miscompares++;
      $display("FAIL rst_release got busy=%b key=%h exp 0/0",
               busy, keyinput);
    end
    run_frame(C432_KEY, 1'b1, -1, lat);
    vectors++;
    if (keyinput !== C432_KEY || key_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_reload got %h/%b exp %h/1",
               keyinput, key_ready, C432_KEY);
    end
  endtask

`ifdef SARLOCK_KEY_PARITY_EN
  task automatic test_fail();
    int lat;
    run_frame(C432_KEY, 1'b0, -1, lat);
    vectors++;
    if (key_err !== 1'b1 || keyinput !== '0 || key_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fail1 got err=%b key=%h rdy=%b exp 1/0/0",
               key_err, keyinput, key_ready);
    end
    vectors++;
    if (lockout !== 1'b0) begin
      miscompares++;
      $display("FAIL fail1_lock got %b exp 0", lockout);
    end
    run_frame(C432_KEY, 1'b0, -1, lat);
    run_frame(C432_KEY, 1'b1, -1, lat);
    vectors++;
    if (key_err !== 1'b0 || keyinput !== C432_KEY) begin
      miscompares++;
      $display("FAIL good_clears got err=%b key=%h exp 0/%h",
               key_err, keyinput, C432_KEY);
    end
    run_frame(C432_KEY, 1'b0, -1, lat);
    run_frame(C432_KEY, 1'b0, -1, lat);
    vectors++;
    if (lockout !== 1'b0) begin
      miscompares++;
      $display("FAIL fail_cnt_clear got lock=%b exp 0", lockout);
    end
    run_frame(C432_KEY, 1'b0, -1, lat);
    vectors++;
    if (lockout !== 1'b1) begin
      miscompares++;
      $display("FAIL fail3_lock got %b exp 1", lockout);
    end
    key_start = 1'b1;
    @(negedge clk);
    key_start = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || lockout !== 1'b1) begin
      miscompares++;
      $display("FAIL locked_start got busy=%b lock=%b exp 0/1",
               busy, lockout);
    end
  endtask
`else
  task automatic test_fail();
    vectors++;
    if (key_err !== 1'b0 || lockout !== 1'b0) begin
      miscompares++;
      $display("FAIL tied_err got err=%b lock=%b exp 0/0",
               key_err, lockout);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    key_start = 1'b0;
    key_sdi = 1'b0;
    key_sen = 1'b0;
    test_reset();
    test_load();
    test_stall();
    test_restart();
    test_rst_mid();
    test_fail();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
